alarm_unit: RTL and testbench
=============================

# alarm_unit

Alarm stage of the Basys3 digital clock, directly downstream of the time-keeping core and upstream of the buzzer pin and VGA overlay. It holds a user-settable alarm time, compares it with the running time, and drives a gated square-wave tone on `buzzer` when they match. It exports the alarm time and ringing status so the display stage can show them.

## Interface
Parameters:
- `TONE_DIV`, 25000: clk cycles per tone half-period. At 100 MHz this gives 2 kHz.
- `BEEP_DIV`, 25000000: clk cycles per beep-gate half-period. At 100 MHz this is 0.25 s on, 0.25 s off.
- `RING_SECS`, 60: `sec_tick` pulses before ringing times out.

Ports:
- `clk_100MHz`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: synchronous, active-high.
- `sec_tick`, in, 1: one-cycle pulse per second from the time core.
- `cur_hr`, in, 5: current hour, binary 0–23.
- `cur_min`, in, 6: current minute, 0–59.
- `cur_sec`, in, 6: current second, 0–59.
- `set_alarm`, in, 1: level. 1 selects alarm-edit mode.
- `alarm_en`, in, 1: level. 1 arms the alarm.
- `tick_hr`, in, 1: debounced one-cycle pulse that increments the alarm hour. Honoured only while `set_alarm`=1.
- `tick_min`, in, 1: debounced one-cycle pulse that increments the alarm minute. Honoured only while `set_alarm`=1.
- `alm_hr`, out, 5: alarm hour, registered.
- `alm_min`, out, 6: alarm minute, registered.
- `ringing`, out, 1: 1 while the FSM is in RINGING.
- `buzzer`, out, 1: tone output, registered.

## Operation
- Reset values: `alm_hr`=0, `alm_min`=0, state=DISARMED, `ringing`=0, `buzzer`=0, all counters 0.
- Alarm edit, when `set_alarm`=1:
  - `tick_min` increments `alm_min`, wrapping 59→0 with no carry into the hour.
  - `tick_hr` increments `alm_hr`, wrapping 23→0.
  - If both pulses arrive in the same cycle, both apply.
  - Ticks arriving while `set_alarm`=0 are ignored.
- Match condition: `cur_hr`==`alm_hr` and `cur_min`==`alm_min` and `cur_sec`==0.
- FSM states: DISARMED, ARMED, RINGING, HOLD. The transitions are listed by priority, highest first.
  - Any state, `alarm_en`=0 → DISARMED.
  - DISARMED, `alarm_en`=1 → ARMED.
  - ARMED, match and `set_alarm`=0 → RINGING. No trigger can occur while editing.
  - RINGING, `set_alarm`=1 (user acknowledge) → HOLD.
  - RINGING, `RING_SECS` sec_ticks counted since entry → HOLD.
  - HOLD, `cur_min`≠`alm_min` or `cur_hr`≠`alm_hr` → ARMED. This prevents retriggering within the same minute.
- Tone generator, active only in RINGING:
  - The tone divider toggles `tone` every `TONE_DIV` cycles.
  - The gate divider toggles `gate` every `BEEP_DIV` cycles.
  - `buzzer` = `tone` & `gate`.
  - Both dividers clear and both `tone` and `gate` load 1 on the entry cycle.
  - Outside RINGING, `buzzer`=0 and both dividers are held at 0.
- Ring counter:
  - Clears on entry to RINGING.
  - Increments on `sec_tick` while in RINGING.
  - A `sec_tick` on the entry cycle itself is not counted.

## Timing
- Match at edge N while ARMED → state=RINGING, `ringing`=1 and `buzzer`=1 all visible after edge N+1.
- First `buzzer` fall occurs `TONE_DIV` cycles after entry, since `gate` is still 1 at that point.
- `alarm_en` deassert or `reset` mid-ring → `buzzer`=0 and `ringing`=0 after the next edge.
  - `reset` additionally restores `alm_*` to 00:00.
- Timeout: the edge that registers the `RING_SECS`-th tick also moves the state to HOLD, so `buzzer`=0 from that edge.
- `tick_*` → `alm_*` updated one cycle later.

## Structure
- Shared clock package/header holds:
  - `MAX_HR`=23, `MAX_MIN`=59, `MAX_SEC`=59.
  - Width constants: 5 for hours, 6 for minutes and seconds.
  - The alarm state encoding: DISARMED=0, ARMED=1, RINGING=2, HOLD=3.
- Sub-module `tone_gen` contains the two dividers and the `buzzer` register.
  - Inputs: `clk_100MHz`, `reset`, `run`.
  - Output: `buzzer`.
  - `run` is the RINGING decode. A 0→1 edge on `run` re-initialises the dividers, `tone` and `gate`.
- `alarm_unit` contains the alarm-time registers, the match compare, the FSM and the ring counter.

## Test plan
Bench parameters: `TONE_DIV`=4, `BEEP_DIV`=16, `RING_SECS`=3.
- Reset then idle → `alm`=00:00, `buzzer`=0, `ringing`=0, state DISARMED.
- Edit wrap: `set_alarm`=1, 60 `tick_min` pulses and 25 `tick_hr` pulses → `alm`=01:00.
  - Also pulse both in one cycle and check `alm_hr` and `alm_min` each advance by 1.
- Trigger and tone: `alm`=07:30, `alarm_en`=1, drive time 07:30:00.
  - `ringing`=1 one cycle later.
  - `buzzer` pattern is 1111 0000 for 16 cycles, then 0 for 16 cycles.
- Timeout and no retrigger: ringing, 3 `sec_tick` pulses → HOLD, `buzzer`=0.
  - Re-presenting 07:30:00 does not ring.
  - 07:31:00 → ARMED.
- Abort: during RINGING, `alarm_en`→0 → `buzzer`=0 next cycle.
  - Separately, `set_alarm`=1 → HOLD.
  - Separately, `reset` → `alm`=00:00 and DISARMED.
- Edit guard: match presented while `set_alarm`=1 and ARMED → no ring.

Source files
------------

// File: rtl/alarm_unit_pkg.sv
// Shared time-keeping constants, field types and alarm state encoding
// for the Basys3 digital clock.
package alarm_unit_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam int MAX_HR  = 23;
  localparam int MAX_MIN = 59;
  localparam int MAX_SEC = 59;

  typedef logic [HR_W-1:0]  hr_t;
  typedef logic [MIN_W-1:0] min_t;
  typedef logic [SEC_W-1:0] sec_t;

  localparam logic [1:0] ST_DISARMED = 2'd0;
  localparam logic [1:0] ST_ARMED    = 2'd1;
  localparam logic [1:0] ST_RINGING  = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  function automatic hr_t inc_hr(input hr_t v);
    return (v == hr_t'(MAX_HR)) ? '0 : v + hr_t'(1);
  endfunction

  function automatic min_t inc_min(input min_t v);
    return (v == min_t'(MAX_MIN)) ? '0 : v + min_t'(1);
  endfunction

endpackage

// File: rtl/alarm_unit_if.sv
// Bundle between the time core / button front end (master) and the
// alarm stage (slave), including the outputs to the buzzer and display.
interface alarm_unit_if;
  import alarm_unit_pkg::*;

  logic sec_tick;
  hr_t  cur_hr;
  min_t cur_min;
  sec_t cur_sec;
  logic set_alarm;
  logic alarm_en;
  logic tick_hr;
  logic tick_min;
  hr_t  alm_hr;
  min_t alm_min;
  logic ringing;
  logic buzzer;

  modport master (
    output sec_tick, cur_hr, cur_min, cur_sec,
    output set_alarm, alarm_en, tick_hr, tick_min,
    input  alm_hr, alm_min, ringing, buzzer
  );

  modport slave (
    input  sec_tick, cur_hr, cur_min, cur_sec,
    input  set_alarm, alarm_en, tick_hr, tick_min,
    output alm_hr, alm_min, ringing, buzzer
  );

endinterface

// File: rtl/alarm_unit_tone_gen.sv
// Gated square-wave tone: a fast tone divider ANDed with a slow beep gate,
// restarted from a known phase each time run rises.
module tone_gen #(
  parameter int TONE_DIV = 25000,
  parameter int BEEP_DIV = 25000000
) (
  input  logic clk_100MHz,
  input  logic reset,
  input  logic run,
  output logic buzzer
);

  localparam int TW = $clog2(TONE_DIV + 1);
  localparam int BW = $clog2(BEEP_DIV + 1);

  logic [TW-1:0] tone_cnt;
  logic [BW-1:0] gate_cnt;
  logic          tone;
  logic          gate;
  logic          run_d;
  logic          entry;
  logic          tone_wrap;
  logic          gate_wrap;
  logic          tone_nxt;
  logic          gate_nxt;

  assign entry     = run && !run_d;
  assign tone_wrap = (tone_cnt == TW'(TONE_DIV - 1));
  assign gate_wrap = (gate_cnt == BW'(BEEP_DIV - 1));

  // buzzer registers the post-edge tone/gate so it rises on the entry edge
  always_comb begin
    tone_nxt = tone;
    gate_nxt = gate;
    if (entry) begin
      tone_nxt = 1'b1;
      gate_nxt = 1'b1;
    end else if (run) begin
      if (tone_wrap) tone_nxt = ~tone;
      if (gate_wrap) gate_nxt = ~gate;
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      tone_cnt <= '0;
      gate_cnt <= '0;
      tone     <= 1'b0;
      gate     <= 1'b0;
      run_d    <= 1'b0;
      buzzer   <= 1'b0;
    end else begin
      run_d  <= run;
      tone   <= tone_nxt;
      gate   <= gate_nxt;
      buzzer <= run & tone_nxt & gate_nxt;
      if (!run || entry) begin
        tone_cnt <= '0;
        gate_cnt <= '0;
      end else begin
        tone_cnt <= tone_wrap ? '0 : tone_cnt + 1'b1;
        gate_cnt <= gate_wrap ? '0 : gate_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: editable alarm time, match against the running clock,
// ring/hold FSM with a seconds-based timeout, and the buzzer tone.
module alarm_unit
  import alarm_unit_pkg::*;
#(
  parameter int TONE_DIV  = 25000,
  parameter int BEEP_DIV  = 25000000,
  parameter int RING_SECS = 60
) (
  input  logic         clk_100MHz,
  input  logic         reset,
  alarm_unit_if.slave  bus
);

  localparam int RW = $clog2(RING_SECS + 1);

  hr_t           alm_hr;
  min_t          alm_min;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [RW-1:0] ring_cnt;
  logic          time_differs;
  logic          match;
  logic          ring_done;
  logic          run;

  assign time_differs = (bus.cur_hr != alm_hr) || (bus.cur_min != alm_min);
  assign match        = !time_differs && (bus.cur_sec == '0);
  assign ring_done    = bus.sec_tick && (ring_cnt == RW'(RING_SECS - 1));

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      alm_hr  <= '0;
      alm_min <= '0;
    end else if (bus.set_alarm) begin
      if (bus.tick_hr)  alm_hr  <= inc_hr(alm_hr);
      if (bus.tick_min) alm_min <= inc_min(alm_min);
    end
  end

  // HOLD waits for the clock to leave the alarm minute so the same match
  // cannot retrigger after an acknowledge or timeout
  always_comb begin
    state_nxt = state;
    if (!bus.alarm_en) begin
      state_nxt = ST_DISARMED;
    end else begin
      case (state)
        ST_DISARMED: state_nxt = ST_ARMED;
        ST_ARMED:    if (match && !bus.set_alarm) state_nxt = ST_RINGING;
        ST_RINGING:  if (bus.set_alarm || ring_done) state_nxt = ST_HOLD;
        ST_HOLD:     if (time_differs) state_nxt = ST_ARMED;
        default:     state_nxt = ST_DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      state    <= ST_DISARMED;
      ring_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state != ST_RINGING) ring_cnt <= '0;
      else if (bus.sec_tick)   ring_cnt <= ring_cnt + 1'b1;
    end
  end

  // Next-state decode lets buzzer start and stop on the same edge as ringing
  assign run = (state_nxt == ST_RINGING);

  tone_gen #(
    .TONE_DIV (TONE_DIV),
    .BEEP_DIV (BEEP_DIV)
  ) u_tone_gen (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .run        (run),
    .buzzer     (bus.buzzer)
  );

  assign bus.alm_hr  = alm_hr;
  assign bus.alm_min = alm_min;
  assign bus.ringing = (state == ST_RINGING);

endmodule

// File: tb/tb_alarm_unit.sv
// Scoreboard bench for alarm_unit: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the alarm rules.
module tb_alarm_unit;
  import alarm_unit_pkg::*;

  localparam int TONE_DIV  = 4;
  localparam int BEEP_DIV  = 16;
  localparam int RING_SECS = 3;

  localparam int M_OFF   = 0;
  localparam int M_ARMED = 1;
  localparam int M_RING  = 2;
  localparam int M_HOLD  = 3;

  typedef struct {
    int alm_hr;
    int alm_min;
    bit ringing;
    bit buzzer;
  } exp_t;

  logic clk_100MHz = 1'b0;
  logic reset;

  alarm_unit_if bus ();

  alarm_unit #(
    .TONE_DIV  (TONE_DIV),
    .BEEP_DIV  (BEEP_DIV),
    .RING_SECS (RING_SECS)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 clk_100MHz = ~clk_100MHz;

  exp_t sb_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cycle_no = 0;

  int m_hr = 0;
  int m_min = 0;
  int m_mode = M_OFF;
  int m_age = 0;
  int m_ticks = 0;

  bit s_en = 1'b0;
  bit s_set = 1'b0;
  int s_hr = 0;
  int s_mn = 0;
  int s_sc = 5;

  // Reference: alarm behaviour in terms of whole alarm time, mode and the
  // number of cycles/seconds since the ring started
  task automatic model_step(input bit rst, en, set, thr, tmin, stick,
                            input int hr, mn, sc);
    exp_t e;
    bit   match;
    int   nxt;
    if (rst) begin
      m_hr = 0; m_min = 0; m_mode = M_OFF; m_age = 0; m_ticks = 0;
    end else begin
      match = (hr == m_hr) && (mn == m_min) && (sc == 0);
      nxt = m_mode;
      if (m_mode == M_RING && stick) m_ticks++;
      if (!en)                                           nxt = M_OFF;
      else if (m_mode == M_OFF)                          nxt = M_ARMED;
      else if (m_mode == M_ARMED && match && !set)       nxt = M_RING;
      else if (m_mode == M_RING && set)                  nxt = M_HOLD;
      else if (m_mode == M_RING && m_ticks >= RING_SECS) nxt = M_HOLD;
      else if (m_mode == M_HOLD && (hr != m_hr || mn != m_min)) nxt = M_ARMED;
      if (nxt == M_RING && m_mode != M_RING) begin
        m_age = 0; m_ticks = 0;
      end else if (nxt == M_RING) begin
        m_age++;
      end
      m_mode = nxt;
      if (set && tmin) m_min = (m_min + 1) % 60;
      if (set && thr)  m_hr  = (m_hr + 1) % 24;
    end
    e.alm_hr  = m_hr;
    e.alm_min = m_min;
    e.ringing = (m_mode == M_RING);
    e.buzzer  = e.ringing && ((m_age / TONE_DIV) % 2 == 0) && ((m_age / BEEP_DIV) % 2 == 0);
    sb_q.push_back(e);
  endtask

  task automatic apply_stimulus(input bit rst, en, set, thr, tmin, stick,
                                input int hr, mn, sc);
    reset         = rst;
    bus.alarm_en  = en;
    bus.set_alarm = set;
    bus.tick_hr   = thr;
    bus.tick_min  = tmin;
    bus.sec_tick  = stick;
    bus.cur_hr    = hr_t'(hr);
    bus.cur_min   = min_t'(mn);
    bus.cur_sec   = sec_t'(sc);
    @(posedge clk_100MHz);
    model_step(rst, en, set, thr, tmin, stick, hr, mn, sc);
    #2;
  endtask

  task automatic step(input bit thr, tmin, stick);
    apply_stimulus(1'b0, s_en, s_set, thr, tmin, stick, s_hr, s_mn, s_sc);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    repeat (n) apply_stimulus(1'b1, s_en, s_set, 1'b0, 1'b0, 1'b0, s_hr, s_mn, s_sc);
  endtask

  task automatic set_alarm_to(input int hr, input int mn);
    s_set = 1'b1;
    while (m_hr != hr)  step(1'b1, 1'b0, 1'b0);
    while (m_min != mn) step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_output(input exp_t e);
    checks++;
    if (int'(bus.alm_hr) == e.alm_hr && int'(bus.alm_min) == e.alm_min &&
        bus.ringing == e.ringing && bus.buzzer == e.buzzer) begin
      passes++;
    end else begin
      $display("[TB] FAIL outputs cycle %0d: got alm=%0d:%0d ringing=%0b buzzer=%0b, want alm=%0d:%0d ringing=%0b buzzer=%0b",
               cycle_no, bus.alm_hr, bus.alm_min, bus.ringing, bus.buzzer,
               e.alm_hr, e.alm_min, e.ringing, e.buzzer);
    end
  endtask

  // Monitor: one registered response per edge, popped just after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_100MHz);
      #1;
      cycle_no++;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output(e);
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not complete, got %0d checks", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit r_rst;
    $display("[TB] reset and idle");
    do_reset(3);
    idle(3);

    $display("[TB] alarm edit wrap");
    s_set = 1'b1;
    repeat (60) step(1'b0, 1'b1, 1'b0);
    repeat (25) step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    s_set = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    idle(2);

    $display("[TB] trigger and tone");
    set_alarm_to(7, 30);
    s_set = 1'b0;
    s_en = 1'b1; s_hr = 7; s_mn = 29; s_sc = 59;
    idle(3);
    s_mn = 30; s_sc = 0;
    idle(40);

    $display("[TB] timeout and no retrigger");
    repeat (RING_SECS) begin
      step(1'b0, 1'b0, 1'b1);
      idle(4);
    end
    idle(5);
    s_mn = 31;
    idle(3);
    s_mn = 30;
    idle(5);

    $display("[TB] abort paths");
    s_en = 1'b0;
    idle(3);
    s_en = 1'b1;
    idle(6);
    s_set = 1'b1;
    idle(3);
    s_set = 1'b0;
    s_mn = 31;
    idle(2);
    s_mn = 30;
    idle(6);
    do_reset(1);
    idle(4);

    $display("[TB] edit guard");
    set_alarm_to(7, 30);
    idle(6);
    s_set = 1'b0;
    idle(4);
    s_en = 1'b0;
    idle(2);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 29) == 0) s_en = ~s_en;
      if ($urandom_range(0, 11) == 0) s_set = ~s_set;
      s_hr = ($urandom_range(0, 1) == 1) ? m_hr  : int'($urandom_range(0, 23));
      s_mn = ($urandom_range(0, 1) == 1) ? m_min : int'($urandom_range(0, 59));
      s_sc = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 59));
      apply_stimulus(r_rst, s_en, s_set,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                     $urandom_range(0, 4) == 0, s_hr, s_mn, s_sc);
    end
    idle(2);
    @(posedge clk_100MHz);
    #3;

    checks++;
    if (sb_q.size() == 0) passes++;
    else $display("[TB] FAIL scoreboard drain: got %0d pending entries, want 0", sb_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
